hbridge_gate_driver: RTL and testbench

- Downstream of the PWM stage. Converts the registered PWM carrier and the note-sign bit into four H-bridge FET gate signals.
- Guarantees dead time on each leg and a full-off interval on polarity reversal.
- Latches an overcurrent fault.
- Sits between the PWM stage and the board's FET driver pins. Clocked by the 40 MHz system clock.

---
 rtl/hbridge_gate_driver.sv | 150 +++++++++++++++
 tb/tb_hbridge_gate_driver.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hbridge_gate_driver.sv
// H-bridge gate driver: turns the registered PWM carrier and note sign into four FET gates,
// with per-leg dead time, a full-off interval on polarity reversal and a latched overcurrent
// fault.
// Build option: define SYNC_RECT_EN to drive the PWM leg's low side complementary to the
// carrier (synchronous rectification); otherwise that low side is never driven.
module hbridge_gate_driver #(
    parameter int unsigned DEAD_CYCLES = 4,
    parameter int unsigned REV_CYCLES  = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic sign,
    input  logic carrier,
    input  logic fault,
    output logic hiA,
    output logic loA,
    output logic hiB,
    output logic loB,
    output logic faulted
);

    typedef enum logic [1:0] {StOff, StPos, StNeg, StRev} state_t;
    typedef enum logic [1:0] {ReqOff, ReqHigh, ReqLow} req_t;

    localparam logic [3:0] DeadSat  = 4'(DEAD_CYCLES);
    localparam logic [3:0] DeadM1   = 4'(DEAD_CYCLES - 1);
    localparam logic [7:0] RevLoad  = 8'(REV_CYCLES);

    state_t     state_q;
    logic       sign_q, carrier_q, faulted_q, target_q;
    logic [7:0] rev_cnt_q;
    logic [1:0] hi_q, lo_q;          // index 0 = leg A, 1 = leg B
    logic [3:0] off_cnt_q [2];       // consecutive both-off periods, saturating
    req_t       req [2];
    req_t       pwm_req;
    logic       kill;

    // Fault input or latched fault forces everything off at this very edge.
    assign kill = fault | faulted_q;

    // Input stage: sign, carrier and the fault latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_q    <= 1'b0;
            carrier_q <= 1'b0;
            faulted_q <= 1'b0;
        end else begin
            sign_q    <= sign;
            carrier_q <= carrier;
            // Clears only while enable is low and fault is low.
            faulted_q <= fault | (faulted_q & enable);
        end
    end

    // Bridge FSM: OFF / POS / NEG / REV with reversal interval counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StOff;
            rev_cnt_q <= 8'd0;
            target_q  <= 1'b0;
        end else if (!enable || kill) begin
            state_q <= StOff;
        end else begin
            unique case (state_q)
                StOff: state_q <= sign_q ? StNeg : StPos;
                StPos: begin
                    if (sign_q) begin
                        state_q   <= StRev;
                        rev_cnt_q <= RevLoad;
                        target_q  <= 1'b1;
                    end
                end
                StNeg: begin
                    if (!sign_q) begin
                        state_q   <= StRev;
                        rev_cnt_q <= RevLoad;
                        target_q  <= 1'b0;
                    end
                end
                StRev: begin
                    if (sign_q != target_q) begin
                        rev_cnt_q <= RevLoad;
                        target_q  <= sign_q;
                    end else if (rev_cnt_q <= 8'd1) begin
                        state_q <= target_q ? StNeg : StPos;
                    end else begin
                        rev_cnt_q <= rev_cnt_q - 8'd1;
                    end
                end
                default: state_q <= StOff;
            endcase
        end
    end

    // Per-leg gate requests from the bridge state and registered carrier.
    always_comb begin
`ifdef SYNC_RECT_EN
        pwm_req = carrier_q ? ReqHigh : ReqLow;
`else
        pwm_req = carrier_q ? ReqHigh : ReqOff;
`endif
        req[0] = ReqOff;
        req[1] = ReqOff;
        unique case (state_q)
            StPos: begin
                req[0] = pwm_req;
                req[1] = ReqLow;
            end
            StNeg: begin
                req[0] = ReqLow;
                req[1] = pwm_req;
            end
            default: ;
        endcase
    end

    // Leg generators: turn-off at the next edge, turn-on only after DEAD_CYCLES both-off periods.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= 2'b00;
            lo_q <= 2'b00;
            for (int i = 0; i < 2; i++) off_cnt_q[i] <= DeadSat;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (kill) begin
                    hi_q[i] <= 1'b0;
                    lo_q[i] <= 1'b0;
                end else begin
                    hi_q[i] <= (req[i] == ReqHigh) &&
                               (hi_q[i] || (!lo_q[i] && off_cnt_q[i] >= DeadM1));
                    lo_q[i] <= (req[i] == ReqLow) &&
                               (lo_q[i] || (!hi_q[i] && off_cnt_q[i] >= DeadM1));
                end
                if (hi_q[i] || lo_q[i]) begin
                    off_cnt_q[i] <= 4'd0;
                end else if (off_cnt_q[i] < DeadSat) begin
                    off_cnt_q[i] <= off_cnt_q[i] + 4'd1;
                end
            end
        end
    end

    assign hiA     = hi_q[0];
    assign loA     = lo_q[0];
    assign hiB     = hi_q[1];
    assign loB     = lo_q[1];
    assign faulted = faulted_q;

endmodule

// File: tb/tb_hbridge_gate_driver.sv
// Self-checking bench for hbridge_gate_driver: directed steps then randomized stimulus,
// compared every cycle against an edge-indexed behavioural model.
module tb_hbridge_gate_driver;

    localparam int DEAD = 4;
    localparam int REV  = 16;
`ifdef SYNC_RECT_EN
    localparam bit SR = 1'b1;
`else
    localparam bit SR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, enable, sign, carrier, fault;
    logic hiA, loA, hiB, loB, faulted;

    int checks   = 0;
    int failures = 0;

    hbridge_gate_driver #(.DEAD_CYCLES(DEAD), .REV_CYCLES(REV)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .sign    (sign),
        .carrier (carrier),
        .fault   (fault),
        .hiA     (hiA),
        .loA     (loA),
        .hiB     (hiB),
        .loB     (loB),
        .faulted (faulted)
    );

    always #5 clk = ~clk;

    // Model state: mode 0=off 1=pos 2=neg 3=reversing; gates indexed by leg (0=A, 1=B).
    int cyc;
    int mode, rev_until, pol;
    bit m_flt, m_sq, m_cq;
    bit mh [2];
    bit ml [2];
    int off_since [2];

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        mode = 0; rev_until = 0; pol = 0;
        m_flt = 0; m_sq = 0; m_cq = 0;
        for (int i = 0; i < 2; i++) begin
            mh[i] = 0; ml[i] = 0; off_since[i] = cyc - 100;
        end
    endtask

    // Applies one clock edge's worth of rules to the model using the current input values.
    task automatic model_edge();
        bit kill;
        int want [2];   // 0 none, 1 high side, 2 low side
        int pwm;
        bit nh, nl, was_off, ok;
        cyc++;
        kill = fault || m_flt;
        pwm = m_cq ? 1 : (SR ? 2 : 0);
        want[0] = (mode == 1) ? pwm : (mode == 2) ? 2 : 0;
        want[1] = (mode == 2) ? pwm : (mode == 1) ? 2 : 0;
        for (int i = 0; i < 2; i++) begin
            was_off = !mh[i] && !ml[i];
            ok = was_off && (cyc - off_since[i] >= DEAD);
            nh = !kill && want[i] == 1 && (mh[i] || ok);
            nl = !kill && want[i] == 2 && (ml[i] || ok);
            if (!was_off && !nh && !nl) off_since[i] = cyc;
            mh[i] = nh; ml[i] = nl;
        end
        if (!enable || kill) mode = 0;
        else if (mode == 0) mode = m_sq ? 2 : 1;
        else if (mode != 3) begin
            if (int'(m_sq) != mode - 1) begin
                mode = 3; pol = m_sq; rev_until = cyc + REV;
            end
        end else if (int'(m_sq) != pol) begin
            pol = m_sq; rev_until = cyc + REV;
        end else if (cyc == rev_until) mode = pol + 1;
        m_flt = fault || (m_flt && enable);
        m_sq = sign;
        m_cq = carrier;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("hiA", hiA, mh[0]);
        chk("loA", loA, ml[0]);
        chk("hiB", hiB, mh[1]);
        chk("loB", loB, ml[1]);
        chk("faulted", faulted, m_flt);
        chk("legA_shoot_through", hiA & loA, 1'b0);
        chk("legB_shoot_through", hiB & loB, 1'b0);
    endtask

    task automatic drive(input bit en, input bit sg, input bit car, input bit flt, input int n);
        enable = en; sign = sg; carrier = car; fault = flt;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        cyc = 0;
        reset = 1'b1; enable = 0; sign = 0; carrier = 0; fault = 0;
        #12;
        chk("rst_hiA", hiA, 1'b0);
        chk("rst_loA", loA, 1'b0);
        chk("rst_hiB", hiB, 1'b0);
        chk("rst_loB", loB, 1'b0);
        chk("rst_faulted", faulted, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Directed: bring-up, carrier edge, short pulse, reversal with mid-count re-flip, fault.
        drive(1, 0, 0, 0, 9);
        drive(1, 0, 1, 0, 10);
        drive(1, 0, 0, 0, 10);
        drive(1, 0, 1, 0, 2);
        drive(1, 0, 0, 0, 12);
        drive(1, 1, 1, 0, 25);
        drive(1, 1, 0, 0, 3);
        drive(1, 1, 1, 0, 3);
        drive(1, 0, 1, 0, 8);
        drive(1, 1, 1, 0, 5);
        drive(1, 0, 1, 0, 25);
        drive(1, 0, 1, 1, 1);
        drive(1, 0, 1, 0, 6);
        drive(0, 0, 1, 0, 2);
        drive(1, 0, 1, 0, 12);
        drive(1, 0, 0, 0, 1);
        drive(1, 0, 1, 0, 1);
        drive(1, 0, 0, 0, 1);
        drive(1, 0, 1, 0, 8);

        // Randomized: slow sign/enable changes, frequent carrier changes, rare faults.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 2) == 0) carrier = ~carrier;
            if ($urandom_range(0, 59) == 0) sign = ~sign;
            enable = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
            fault  = ($urandom_range(0, 149) == 0);
            if (k == 1500) begin
                #2 reset = 1'b1;
                #1;
                chk("async_rst_hiA", hiA, 1'b0);
                chk("async_rst_loA", loA, 1'b0);
                chk("async_rst_hiB", hiB, 1'b0);
                chk("async_rst_loB", loB, 1'b0);
                chk("async_rst_faulted", faulted, 1'b0);
                @(posedge clk);
                #2 reset = 1'b0;
                model_reset();
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
